// File: rtl/fetch_pkg.sv
// Shared types and constants for the miniRV instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } fetch_state_e;

  localparam logic [31:0] EBREAK_INSN  = 32'h0010_0073;
  localparam int unsigned INSN_BYTES   = 4;
  localparam int unsigned FETCH_ADDR_W = 32;

  typedef struct packed {
    logic [31:0]             instr;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory request/response and decode valid/ready bundle of the fetch unit.
interface fetch_controller_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = FETCH_ADDR_W
) ();

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_instr;
  logic [ADDR_W-1:0] if_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc
  );

endinterface

// File: rtl/fetch_fifo2.sv
// Two-entry fetch buffer; slot 0 is always the head. Flush beats push.
module fetch_fifo2
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  logic [1:0]   r_count;
  fetch_entry_t r_slot0;
  fetch_entry_t r_slot1;
  logic [1:0]   w_count_after_pop;

  assign w_count_after_pop = r_count - 2'(i_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      // Shift on pop first; a concurrent push lands in the slot freed by the pop.
      if (i_pop && (r_count == 2'd2)) begin
        r_slot0 <= r_slot1;
      end
      if (i_push) begin
        if (w_count_after_pop == 2'd0) begin
          r_slot0 <= i_data;
        end else begin
          r_slot1 <= i_data;
        end
      end
      r_count <= w_count_after_pop + 2'(i_push);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_slot0;

endmodule

// File: rtl/fetch_controller.sv
// miniRV fetch sequencer: owns the PC, issues 1-cycle-latency imem reads, buffers
// results for decode, and handles redirects, EBREAK halt and misaligned targets.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_controller_if.master  bus,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                halted,
  output logic                misalign_err
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic              r_inflight;
  logic              r_misalign;

  logic              w_issue;
  logic              w_flush;
  logic              w_kill;
  logic              w_load_redirect;
  logic              w_set_misalign;
  logic              w_room;

  logic [1:0]        w_fifo_count;
  fetch_entry_t      w_fifo_head;
  fetch_entry_t      w_resp_entry;
  fetch_entry_t      w_head;
  logic              w_fifo_push;
  logic              w_fifo_pop;
  logic              w_head_in_fifo;
  logic              w_avail;
  logic              w_pop;
  logic              w_ebreak_take;
  logic [2:0]        w_occupancy;

  assign w_resp_entry   = '{instr: bus.imem_rdata, pc: FETCH_ADDR_W'(r_resp_pc)};
  assign w_head_in_fifo = (w_fifo_count != 2'd0);

  // The arriving response bypasses the buffer when it is empty, giving issue-to-valid in one cycle.
  assign w_head         = w_head_in_fifo ? w_fifo_head : w_resp_entry;
  assign w_avail        = (r_state == ST_RUN) && (w_head_in_fifo || r_inflight);
  assign w_pop          = w_avail && bus.if_ready;
  assign w_ebreak_take  = w_pop && (w_head.instr == EBREAK_INSN);

  assign w_occupancy    = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_room         = w_occupancy < 3'(FIFO_DEPTH);

  assign w_fifo_push    = r_inflight && !(w_pop && !w_head_in_fifo);
  assign w_fifo_pop     = w_pop && w_head_in_fifo;

  fetch_fifo2 u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_fifo_push),
    .i_pop   (w_fifo_pop),
    .i_flush (w_flush),
    .i_data  (w_resp_entry),
    .o_count (w_fifo_count),
    .o_head  (w_fifo_head)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_issue         = 1'b0;
    w_flush         = 1'b0;
    w_kill          = 1'b0;
    w_load_redirect = 1'b0;
    w_set_misalign  = 1'b0;
    unique case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_issue = w_room && !redirect_valid;
        if (redirect_valid) begin
          w_flush = 1'b1;
          w_kill  = 1'b1;
          if (is_word_aligned(redirect_pc[1:0])) begin
            w_load_redirect = 1'b1;
          end else begin
            w_set_misalign = 1'b1;
            w_state_nxt    = ST_HALT;
          end
        end else if (w_ebreak_take) begin
          w_flush     = 1'b1;
          w_kill      = 1'b1;
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_PC;
      r_resp_pc  <= '0;
      r_inflight <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue && !w_kill;
      if (w_issue) begin
        r_resp_pc <= r_pc;
      end
      if (w_load_redirect) begin
        r_pc <= redirect_pc;
      end else if (w_issue) begin
        r_pc <= r_pc + ADDR_W'(INSN_BYTES);
      end
      if (w_set_misalign) begin
        r_misalign <= 1'b1;
      end
    end
  end

  assign bus.imem_req  = w_issue;
  assign bus.imem_addr = r_pc;
  assign bus.if_valid  = w_avail;
  assign bus.if_instr  = w_avail ? w_head.instr : '0;
  assign bus.if_pc     = w_avail ? ADDR_W'(w_head.pc) : '0;
  assign halted        = (r_state == ST_HALT);
  assign misalign_err  = r_misalign;

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences instruction fetch for the miniRV core. It owns the PC and drives a synchronous-read instruction memory with one-cycle read latency. Fetched instruction/PC pairs are buffered in a 2-entry queue and handed to decode over a valid/ready handshake. It handles branch/jump redirects from execute, halts on EBREAK, and flags misaligned redirect targets.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
ADDR_W, 32, PC/address width
FIFO_DEPTH, 2, decode-side buffer entries (fixed at 2; other values are unsupported)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  read request this cycle
imem_addr  out  ADDR_W  byte address of request (always 4-aligned)
imem_rdata  in  32  read data, valid the cycle after imem_req
if_valid  out  1  if_instr/if_pc valid to decode
if_ready  in  1  decode accepts; transfer when if_valid && if_ready
if_instr  out  32  instruction word
if_pc  out  ADDR_W  PC of if_instr
redirect_valid  in  1  execute redirect (taken branch/jump)
redirect_pc  in  ADDR_W  redirect target
halted  out  1  sticky, fetch stopped
misalign_err  out  1  sticky, halt was caused by a misaligned redirect

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, halted=0, misalign_err=0. Queue empty, no request in flight, state=BOOT.
- States:
  - BOOT: one cycle after rst_n deasserts, no request issued, then RUN.
  - RUN: normal fetching.
  - HALT: terminal until reset.
- Issue rule (RUN only): assert imem_req with imem_addr=PC when (count − pop + inflight) < 2.
  - pop = if_valid && if_ready this cycle.
  - inflight = request issued last cycle and not killed.
  - On issue, PC <= PC+4, modulo 2^ADDR_W; wrap from 32'hFFFF_FFFC to 0 is legal.
- Response: in the cycle after issue, imem_rdata is pushed with its PC unless killed. The issue rule guarantees no overflow.
- Output: if_valid = queue non-empty; if_instr/if_pc = head entry. The head is held stable while if_valid && !if_ready.
- Latency: issue at N → if_valid at N+1 if the queue was empty. From reset release, the first request is at cycle 1 and the first if_valid at cycle 2.
- Redirect (redirect_valid=1 in RUN), same cycle:
  - flush the queue;
  - kill any in-flight response;
  - suppress this cycle's issue;
  - PC <= redirect_pc.
  - The first request to the target is at N+1 and its if_valid at N+2.
  - Any if_valid/if_ready transfer in cycle N still completes.
- Misaligned redirect (redirect_pc[1:0] != 0): flush as for a redirect, then go to HALT with halted=1 and misalign_err=1 from N+1. No request is issued to the target.
- EBREAK (32'h0010_0073) accepted at the output in cycle N without a redirect in N:
  - flush younger entries;
  - kill any in-flight response;
  - go to HALT with halted=1 from N+1;
  - imem_req=0 from N+1.
- Simultaneous redirect and EBREAK accept: redirect wins (EBREAK is on the wrong path), so no halt.
- HALT: imem_req=0, if_valid=0, redirect ignored.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). A response arriving after reset release is ignored because inflight was cleared.

Decomposition:
- Package fetch_pkg:
  - state enum (BOOT, RUN, HALT);
  - EBREAK_INSN = 32'h0010_0073;
  - INSN_BYTES = 4;
  - typedef fetch_entry_t {instr[31:0], pc[ADDR_W-1:0]}.
- Sub-module fetch_fifo2: 2-entry FIFO of fetch_entry_t with push, pop, flush, count and head outputs.
  - Flush has priority over push in the same cycle.
  - Simultaneous push and pop when full is not permitted, because the issue rule prevents it.

Test Plan:
- Reset release, RESET_PC=0, if_ready=1 → imem_addr 0,4,8,… on consecutive cycles from cycle 1; if_pc 0,4,8 with if_valid from cycle 2, one instruction per cycle.
- if_ready=0 for 5 cycles from the first if_valid → queue fills to 2, imem_req drops, if_pc=0 held stable; on if_ready=1 the sequence 0,4,8 continues with no duplicates or gaps.
- Steady stream, redirect_valid=1 with redirect_pc=0x40 at cycle N → imem_addr=0x40 at N+1, if_pc=0x40 at N+2, no instruction from the old path delivered after N.
- Memory word at 0x8 = 32'h0010_0073 → PCs 0,4,8 delivered, halted=1 the cycle after 8 is accepted, imem_req stays 0, if_valid stays 0.
- redirect_pc=0x42 → halted=1 and misalign_err=1 next cycle, no request to 0x40 or 0x42; a later redirect_valid has no effect.
- Redirect in the same cycle as the EBREAK accept → no halt, fetch resumes at the target. Reset asserted mid-stream → all outputs return to reset values asynchronously.
